uart_rx_axis: RTL and testbench
===============================

UART_RX_AXIS -- requirements
Module: uart_rx_axis

Interface
REQ-001 SHALL have parameter DATA_W, default 8: data bits per frame, LSB first.
REQ-002 SHALL have parameter PRESCALE_W, default 16: width of the prescale input.
REQ-003 SHALL have port clk  input  1: single clock domain for all logic.
REQ-004 SHALL have port rst  input  1: synchronous, active-high reset.
REQ-005 SHALL have port rxd  input  1: asynchronous serial line, idle high.
REQ-006 SHALL have port prescale  input  PRESCALE_W: bit period T = prescale*8 clk cycles; a value of 0 SHALL be treated as 1.
REQ-007 SHALL have port output_axis_tdata  output  DATA_W: received byte.
REQ-008 SHALL have port output_axis_tvalid  output  1: tdata holds an unconsumed byte.
REQ-009 SHALL have port output_axis_tready  input  1: consumer accepts the byte.
REQ-010 SHALL have port busy  output  1: high in any state other than IDLE.
REQ-011 SHALL have port frame_error  output  1: one-cycle pulse when the stop bit samples low.
REQ-012 SHALL have port overrun_error  output  1: one-cycle pulse when a good frame arrives while the output slot is full.

Function
REQ-013 SHALL pass rxd through a 2-flop synchronizer, then a third flop for edge detection; all sampling SHALL use the synchronized value.
REQ-014 SHALL implement FSM states IDLE, START, DATA, STOP.
REQ-015 In IDLE, a synchronized falling edge (previous 1, current 0) SHALL load the bit counter with T/2-1 and enter START.
REQ-016 In START, on counter expiry: rxd=1 -> false start, return to IDLE with no outputs changed; rxd=0 -> load T-1, clear bit index, enter DATA.
REQ-017 In DATA, on each counter expiry the module SHALL shift the sampled rxd into bit[index] and reload T-1; after the DATA_W-th bit it SHALL enter STOP.
REQ-018 In STOP, on counter expiry: rxd=0 -> pulse frame_error, discard the byte, enter IDLE.
REQ-019 In STOP, on counter expiry with rxd=1 and the slot free (tvalid=0, or tvalid=1 and tready=1 that cycle) -> load tdata and hold tvalid=1 from the next cycle, then enter IDLE.
REQ-020 In STOP, on counter expiry with rxd=1 and the slot full (tvalid=1, tready=0) -> pulse overrun_error, keep the old tdata/tvalid, drop the new byte, enter IDLE.
REQ-021 Once raised, tvalid SHALL stay high with tdata stable until a cycle with tready=1; it SHALL deassert the cycle after acceptance, unless REQ-019 reloads it in that same cycle.
REQ-022 A frame following a framing error SHALL only start on a new falling edge, i.e. rxd must return high first.
REQ-023 prescale SHALL be sampled on counter loads only; changing it mid-frame SHALL affect only subsequent bit periods.
REQ-024 The counter SHALL be PRESCALE_W+3 bits wide with no overflow at the maximum prescale.

Reset
REQ-025 rst SHALL force: state IDLE, counter 0, bit index 0, tdata 0, tvalid 0, busy 0, frame_error 0, overrun_error 0, and synchronizer flops to 1.
REQ-026 rst asserted mid-frame SHALL abort the frame with no tvalid or error pulse; the next frame SHALL require a fresh falling edge after reset release.

Verification
REQ-027 prescale=4 (T=32), rxd frame 8N1 0xA5, tready=1 -> tdata=0xA5 with one tvalid pulse about 304 clk (+/-4) after the start edge; no error pulses.
REQ-028 Low glitch on rxd lasting 8 clk, prescale=4 -> busy high for about 18 clk, then back to IDLE; tvalid, frame_error and overrun_error stay 0.
REQ-029 Frame 0x3C with the stop bit driven 0 -> frame_error pulses once, tvalid stays 0; a following good frame 0x5A yields tdata=0x5A.
REQ-030 Back-to-back frames 0x11 then 0x22 with tready=0 -> tdata=0x11 and tvalid=1 held; overrun_error pulses once at the second stop bit; raising tready then yields 0x11 and tvalid drops.
REQ-031 rst pulsed during data bit 4 of frame 0xFF, then frame 0x81 -> nothing emitted for the aborted frame; tdata=0x81 emitted for the new one.
REQ-032 prescale=1 (T=8), frames 0x00 and 0xFF -> both received correctly with tready=1, confirming minimum-rate operation.

Source files
------------

// File: rtl/uart_rx_axis.sv
// uart_rx_axis: 8N1-style UART receiver with an AXI-Stream style output slot.
//
// Ports:
//   clk, rst            - single clock, synchronous active-high reset
//   rxd                 - asynchronous serial input, idle high
//   prescale            - bit period T = prescale*8 clk cycles (0 behaves as 1)
//   output_axis_tdata   - received word, LSB first on the line
//   output_axis_tvalid  - tdata holds an unconsumed word
//   output_axis_tready  - consumer accepts the word this cycle
//   busy                - receiver is not in IDLE
//   frame_error         - one-cycle pulse: stop bit sampled low
//   overrun_error       - one-cycle pulse: good frame dropped, slot was full
//   state_dbg           - current FSM state (IDLE=0, START=1, DATA=2, STOP=3)
//
// Handshake: a word transfers on every rising clk edge where tvalid and tready
// are both high. Once tvalid rises, tvalid and tdata hold until that transfer;
// a new word may be loaded in the same cycle as a transfer.
module uart_rx_axis #(
    parameter int DATA_W     = 8,
    parameter int PRESCALE_W = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rxd,
    input  logic [PRESCALE_W-1:0] prescale,
    output logic [DATA_W-1:0]     output_axis_tdata,
    output logic                  output_axis_tvalid,
    input  logic                  output_axis_tready,
    output logic                  busy,
    output logic                  frame_error,
    output logic                  overrun_error,
    output logic [1:0]            state_dbg
);

    localparam int CNT_W = PRESCALE_W + 3;
    localparam int IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [DATA_W-1:0]   shreg_q, shreg_d;
    logic [DATA_W-1:0]   tdata_q, tdata_d;
    logic                tvalid_q, tvalid_d;
    logic                busy_q, busy_d;
    logic                fe_q, fe_d;
    logic                ov_q, ov_d;
    logic                rxd_s1_q, rxd_s2_q, rxd_s3_q;

    logic [PRESCALE_W-1:0] prescale_eff;
    logic [CNT_W-1:0]      bit_period;
    logic [CNT_W-1:0]      period_m1;
    logic [CNT_W-1:0]      half_m1;
    logic                  expired;

    // prescale is only consumed at counter loads, so a mid-frame change
    // only affects bit periods that start after it.
    assign prescale_eff = (prescale == '0) ? PRESCALE_W'(1) : prescale;
    assign bit_period   = {prescale_eff, 3'b000};
    assign period_m1    = bit_period - CNT_W'(1);
    assign half_m1      = (bit_period >> 1) - CNT_W'(1);
    assign expired      = (cnt_q == '0);

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        idx_d    = idx_q;
        shreg_d  = shreg_q;
        tdata_d  = tdata_q;
        tvalid_d = tvalid_q & ~output_axis_tready;
        fe_d     = 1'b0;
        ov_d     = 1'b0;

        case (state_q)
            IDLE: begin
                // Falling edge on the synchronized line: aim at mid start bit.
                if (rxd_s3_q && !rxd_s2_q) begin
                    cnt_d   = half_m1;
                    state_d = START;
                end
            end
            START: begin
                if (expired) begin
                    if (rxd_s2_q) begin
                        state_d = IDLE;  // glitch, not a real start bit
                    end else begin
                        cnt_d   = period_m1;
                        idx_d   = '0;
                        state_d = DATA;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            DATA: begin
                if (expired) begin
                    shreg_d[idx_q] = rxd_s2_q;
                    cnt_d          = period_m1;
                    if (idx_q == IDX_W'(DATA_W - 1)) begin
                        state_d = STOP;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            STOP: begin
                if (expired) begin
                    state_d = IDLE;
                    if (!rxd_s2_q) begin
                        fe_d = 1'b1;
                    end else if (!tvalid_q || output_axis_tready) begin
                        tdata_d  = shreg_q;
                        tvalid_d = 1'b1;
                    end else begin
                        ov_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            idx_q    <= '0;
            shreg_q  <= '0;
            tdata_q  <= '0;
            tvalid_q <= 1'b0;
            busy_q   <= 1'b0;
            fe_q     <= 1'b0;
            ov_q     <= 1'b0;
            rxd_s1_q <= 1'b1;
            rxd_s2_q <= 1'b1;
            rxd_s3_q <= 1'b1;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            shreg_q  <= shreg_d;
            tdata_q  <= tdata_d;
            tvalid_q <= tvalid_d;
            busy_q   <= busy_d;
            fe_q     <= fe_d;
            ov_q     <= ov_d;
            rxd_s1_q <= rxd;
            rxd_s2_q <= rxd_s1_q;
            rxd_s3_q <= rxd_s2_q;
        end
    end

    assign output_axis_tdata  = tdata_q;
    assign output_axis_tvalid = tvalid_q;
    assign busy               = busy_q;
    assign frame_error        = fe_q;
    assign overrun_error      = ov_q;
    assign state_dbg          = state_q;

endmodule

// File: tb/tb_uart_rx_axis.sv
module tb_uart_rx_axis;

    logic        clk;
    logic        rst;
    logic        rxd;
    logic [15:0] prescale;
    logic [7:0]  tdata;
    logic        tvalid;
    logic        tready;
    logic        busy;
    logic        frame_error;
    logic        overrun_error;
    logic [1:0]  state_dbg;

    int total;
    int bad;
    int rx_cnt;
    int fe_cnt;
    int ov_cnt;

    logic [7:0] exp_q[$];
    logic       prev_hold;
    logic [7:0] prev_data;

    uart_rx_axis #(.DATA_W(8), .PRESCALE_W(16)) dut (
        .clk               (clk),
        .rst               (rst),
        .rxd               (rxd),
        .prescale          (prescale),
        .output_axis_tdata (tdata),
        .output_axis_tvalid(tvalid),
        .output_axis_tready(tready),
        .busy              (busy),
        .frame_error       (frame_error),
        .overrun_error     (overrun_error),
        .state_dbg         (state_dbg)
    );

    // clock / reset block
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog time limit reached total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    // scoreboard: pops expected words on each handshake, checks hold rule
    always @(negedge clk) begin
        if (rst) begin
            prev_hold = 1'b0;
        end else begin
            if (tvalid === 1'b1 && tready === 1'b1) begin
                logic [7:0] e;
                rx_cnt++;
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL unexpected_word got=%h need=none", tdata);
                end else begin
                    e = exp_q.pop_front();
                    if (tdata !== e) begin
                        bad++;
                        $display("FAIL rx_data got=%h need=%h", tdata, e);
                    end
                end
            end
            if (frame_error === 1'b1) fe_cnt++;
            if (overrun_error === 1'b1) ov_cnt++;
            if (prev_hold) begin
                total++;
                if (tvalid !== 1'b1 || tdata !== prev_data) begin
                    bad++;
                    $display("FAIL hold got=%b/%h need=1/%h", tvalid, tdata, prev_data);
                end
            end
            prev_hold = (tvalid === 1'b1) && (tready === 1'b0);
            prev_data = tdata;
        end
    end

    // driver tasks
    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop_val, input int t);
        rxd = 1'b0;
        wait_cyc(t);
        for (int i = 0; i < 8; i++) begin
            rxd = d[i];
            wait_cyc(t);
        end
        rxd = stop_val;
        wait_cyc(t);
        rxd = 1'b1;
    endtask

    task automatic check_int(input string name, input int got, input int need);
        total++;
        if (got !== need) begin
            bad++;
            $display("FAIL %s got=%0d need=%0d", name, got, need);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        wait_cyc(3);
        total++;
        if (tvalid !== 1'b0 || busy !== 1'b0 || frame_error !== 1'b0 ||
            overrun_error !== 1'b0 || tdata !== 8'h00 || state_dbg !== 2'd0) begin
            bad++;
            $display("FAIL reset_state got=%b%b%b%b/%h/%0d need=0000/00/0",
                     tvalid, busy, frame_error, overrun_error, tdata, state_dbg);
        end
        rst = 1'b0;
        wait_cyc(5);
    endtask

    task automatic test_basic();
        int lat;
        int fe0;
        int ov0;
        fe0 = fe_cnt;
        ov0 = ov_cnt;
        prescale = 16'd4;
        tready = 1'b1;
        exp_q.push_back(8'hA5);
        lat = 0;
        fork
            send_frame(8'hA5, 1'b1, 32);
            begin
                while (tvalid !== 1'b1 && lat < 400) begin
                    wait_cyc(1);
                    lat++;
                end
            end
        join
        wait_cyc(10);
        total++;
        if (lat < 300 || lat > 308) begin
            bad++;
            $display("FAIL basic_latency got=%0d need=300..308", lat);
        end
        check_int("basic_fe", fe_cnt - fe0, 0);
        check_int("basic_ov", ov_cnt - ov0, 0);
        check_int("basic_drain", exp_q.size(), 0);
    endtask

    task automatic test_glitch();
        int bcnt;
        int rx0;
        int fe0;
        int ov0;
        rx0 = rx_cnt;
        fe0 = fe_cnt;
        ov0 = ov_cnt;
        bcnt = 0;
        rxd = 1'b0;
        for (int i = 0; i < 8; i++) begin
            wait_cyc(1);
            if (busy === 1'b1) bcnt++;
        end
        rxd = 1'b1;
        for (int i = 0; i < 40; i++) begin
            wait_cyc(1);
            if (busy === 1'b1) bcnt++;
        end
        total++;
        if (bcnt < 14 || bcnt > 22) begin
            bad++;
            $display("FAIL glitch_busy got=%0d need=14..22", bcnt);
        end
        check_int("glitch_idle", state_dbg, 0);
        check_int("glitch_rx", rx_cnt - rx0, 0);
        check_int("glitch_fe", fe_cnt - fe0, 0);
        check_int("glitch_ov", ov_cnt - ov0, 0);
    endtask

    task automatic test_frame_error();
        int rx0;
        int fe0;
        rx0 = rx_cnt;
        fe0 = fe_cnt;
        send_frame(8'h3C, 1'b0, 32);
        wait_cyc(40);
        check_int("ferr_pulse", fe_cnt - fe0, 1);
        check_int("ferr_no_tvalid", rx_cnt - rx0, 0);
        exp_q.push_back(8'h5A);
        send_frame(8'h5A, 1'b1, 32);
        wait_cyc(20);
        check_int("ferr_next_rx", rx_cnt - rx0, 1);
        check_int("ferr_fe_once", fe_cnt - fe0, 1);
        check_int("ferr_drain", exp_q.size(), 0);
    endtask

    task automatic test_back_to_back();
        int ov0;
        ov0 = ov_cnt;
        tready = 1'b0;
        exp_q.push_back(8'h11);
        send_frame(8'h11, 1'b1, 32);
        send_frame(8'h22, 1'b1, 32);
        wait_cyc(20);
        check_int("ovr_pulse", ov_cnt - ov0, 1);
        total++;
        if (tvalid !== 1'b1 || tdata !== 8'h11) begin
            bad++;
            $display("FAIL ovr_slot got=%b/%h need=1/11", tvalid, tdata);
        end
        tready = 1'b1;
        wait_cyc(1);
        wait_cyc(1);
        check_int("ovr_tvalid_drop", tvalid, 0);
        check_int("ovr_drain", exp_q.size(), 0);
    endtask

    task automatic test_reset_midframe();
        int rx0;
        int fe0;
        int ov0;
        rx0 = rx_cnt;
        fe0 = fe_cnt;
        ov0 = ov_cnt;
        fork
            send_frame(8'hFF, 1'b1, 32);
            begin
                wait_cyc(32 * 5 + 16);
                rst = 1'b1;
                wait_cyc(2);
                rst = 1'b0;
            end
        join
        wait_cyc(20);
        check_int("rstmid_rx", rx_cnt - rx0, 0);
        check_int("rstmid_fe", fe_cnt - fe0, 0);
        check_int("rstmid_ov", ov_cnt - ov0, 0);
        check_int("rstmid_idle", state_dbg, 0);
        exp_q.push_back(8'h81);
        send_frame(8'h81, 1'b1, 32);
        wait_cyc(20);
        check_int("rstmid_next_rx", rx_cnt - rx0, 1);
        check_int("rstmid_drain", exp_q.size(), 0);
    endtask

    task automatic test_min_rate();
        int rx0;
        int fe0;
        int ov0;
        rx0 = rx_cnt;
        fe0 = fe_cnt;
        ov0 = ov_cnt;
        prescale = 16'd1;
        tready = 1'b1;
        exp_q.push_back(8'h00);
        exp_q.push_back(8'hFF);
        send_frame(8'h00, 1'b1, 8);
        send_frame(8'hFF, 1'b1, 8);
        wait_cyc(10);
        // prescale 0 behaves like prescale 1
        prescale = 16'd0;
        exp_q.push_back(8'h96);
        send_frame(8'h96, 1'b1, 8);
        wait_cyc(10);
        check_int("minrate_rx", rx_cnt - rx0, 3);
        check_int("minrate_fe", fe_cnt - fe0, 0);
        check_int("minrate_ov", ov_cnt - ov0, 0);
        check_int("minrate_drain", exp_q.size(), 0);
    endtask

    initial begin
        total     = 0;
        bad       = 0;
        rx_cnt    = 0;
        fe_cnt    = 0;
        ov_cnt    = 0;
        prev_hold = 1'b0;
        prev_data = 8'h00;
        rst       = 1'b1;
        rxd       = 1'b1;
        prescale  = 16'd4;
        tready    = 1'b1;
        wait_cyc(1);
        test_reset();
        test_basic();
        test_glitch();
        test_frame_error();
        test_back_to_back();
        test_reset_midframe();
        test_min_rate();
        wait_cyc(5);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
